fetch_queue: RTL

Instruction buffer between the fetch/predecode stage and decode. It accepts up to ENQ_WIDTH `fetchEntry_t` entries per cycle from fetch and stores them in a circular queue. It presents up to DEQ_WIDTH oldest entries per cycle to decode. A squash empties it in one cycle.

---
 rtl/fetch_queue.sv | 122 ++++++++++++
 1 files changed

// File: rtl/fetch_queue.sv
// Fetch-to-decode instruction buffer: a circular queue that accepts up to
// ENQ_WIDTH entries per cycle and presents up to DEQ_WIDTH oldest entries.
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   i_squash_vld      flush all contents in one cycle
//   i_enq_vld/entry   enqueue lanes (contiguous from lane 0, lane 0 oldest)
//   o_can_enq         registered; high when at least ENQ_WIDTH slots are free
//   o_deq_vld/entry   head entries, combinational from registered state
//   i_deq_rdy         decode takes every valid lane, all-or-nothing
//   o_count           current occupancy
package fetch_queue_pkg;
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    logic        pred_taken;
  } fetch_entry_t;
endpackage

module fetch_queue
  import fetch_queue_pkg::*;
#(
  parameter int unsigned DEPTH     = 16,
  parameter int unsigned ENQ_WIDTH = 4,
  parameter int unsigned DEQ_WIDTH = 4
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                i_squash_vld,
  input  logic         [ENQ_WIDTH-1:0]        i_enq_vld,
  input  fetch_entry_t [ENQ_WIDTH-1:0]        i_enq_entry,
  output logic                                o_can_enq,
  output logic         [DEQ_WIDTH-1:0]        o_deq_vld,
  output fetch_entry_t [DEQ_WIDTH-1:0]        o_deq_entry,
  input  logic                                i_deq_rdy,
  output logic         [$clog2(DEPTH):0]      o_count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  fetch_entry_t storage [DEPTH];
  logic [PTR_W-1:0] head;
  logic [PTR_W-1:0] tail;
  logic [CNT_W-1:0] count;
  logic             can_enq;

  logic [CNT_W-1:0] enq_num;
  logic [CNT_W-1:0] deq_num;
  logic [CNT_W-1:0] count_next;
  logic             enq_fire;
  logic             wr_en;

  // Enqueue lane count; lanes are contiguous so popcount equals highest lane + 1.
  always_comb begin
    enq_num = '0;
    for (int k = 0; k < ENQ_WIDTH; k++) begin
      if (i_enq_vld[k]) enq_num = enq_num + CNT_W'(1);
    end
  end

  // Enqueue only when advertised space exists; squash discards the write.
  assign enq_fire = can_enq && (|i_enq_vld);
  assign wr_en    = enq_fire && !i_squash_vld;

  // Dequeue takes every valid lane when decode is ready.
  always_comb begin
    deq_num = '0;
    if (i_deq_rdy) begin
      deq_num = (count < CNT_W'(DEQ_WIDTH)) ? count : CNT_W'(DEQ_WIDTH);
    end
  end

  assign count_next = count + (enq_fire ? enq_num : '0) - deq_num;

  // Pointer, occupancy and flow-control state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head    <= '0;
      tail    <= '0;
      count   <= '0;
      can_enq <= 1'b1;
    end else if (i_squash_vld) begin
      head    <= '0;
      tail    <= '0;
      count   <= '0;
      can_enq <= 1'b1;
    end else begin
      head    <= head + PTR_W'(deq_num);
      if (enq_fire) tail <= tail + PTR_W'(enq_num);
      count   <= count_next;
      can_enq <= (count_next <= CNT_W'(DEPTH - ENQ_WIDTH));
    end
  end

  // Payload storage; not reset and not cleared by squash.
  always_ff @(posedge clk) begin
    for (int k = 0; k < ENQ_WIDTH; k++) begin
      if (wr_en && i_enq_vld[k]) storage[tail + PTR_W'(k)] <= i_enq_entry[k];
    end
  end

  // Head window, wrapping naturally through pointer arithmetic.
  always_comb begin
    for (int k = 0; k < DEQ_WIDTH; k++) begin
      o_deq_vld[k]   = (CNT_W'(k) < count);
      o_deq_entry[k] = storage[head + PTR_W'(k)];
    end
  end

  assign o_can_enq = can_enq;
  assign o_count   = count;

`ifndef SYNTHESIS
  logic [ENQ_WIDTH-1:0] enq_vld_inc;
  assign enq_vld_inc = i_enq_vld + ENQ_WIDTH'(1);

  // Valid lanes must form a contiguous run starting at lane 0.
  enq_contiguous: assert property (@(posedge clk) disable iff (rst)
    ((i_enq_vld & enq_vld_inc) == '0));
`endif

endmodule
